rr_bus_arbiter: RTL and testbench

Two-requester round-robin bus arbiter that shares the single downstream memory/MMIO bus port (the address mapper's upstream side) between requester 0 (CPU) and requester 1 (DMA/secondary master). It serialises transactions one at a time, holds address/data stable for each transaction's full duration, and returns read data and a one-cycle ready pulse to the granted requester. A watchdog terminates downstream transactions that never complete.

---
 rtl/rr_bus_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_rr_bus_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter
//   Two-requester round-robin arbiter in front of a single downstream
//   memory/MMIO port. Transactions are serialised one at a time through
//   IDLE -> ISSUE -> WAIT -> RESP. A watchdog ends any downstream access
//   that does not complete within TIMEOUT WAIT cycles and returns ERR_DATA.
//
// Handshake contract:
//   Requester n raises m<n>_we and/or m<n>_rd (write wins if both) and holds
//   address, data and strobes until it sees m<n>_ready, a registered
//   one-cycle pulse; read data on m<n>_spo is valid in that same cycle.
//   Downstream sees s_we/s_rd for exactly one cycle (ISSUE); s_a/s_d stay
//   stable through WAIT; completion is s_ready high in any WAIT cycle.
//   s_ready outside WAIT is ignored.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   m0_*/m1_*           requester address, write data, we, rd (in);
//                       read data, ready pulse (out)
//   s_a, s_d, s_we, s_rd  downstream request (out)
//   s_spo, s_ready      downstream response (in)
//   timeout_err         pulses with m*_ready of a timed-out transaction
//   dbg_state_o         current arbiter state for observation
module rr_bus_arbiter #(
  parameter int unsigned TIMEOUT  = 1024,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_a,
  input  logic [31:0] m0_d,
  input  logic        m0_we,
  input  logic        m0_rd,
  output logic [31:0] m0_spo,
  output logic        m0_ready,
  input  logic [31:0] m1_a,
  input  logic [31:0] m1_d,
  input  logic        m1_we,
  input  logic        m1_rd,
  output logic [31:0] m1_spo,
  output logic        m1_ready,
  output logic [31:0] s_a,
  output logic [31:0] s_d,
  output logic        s_we,
  output logic        s_rd,
  input  logic [31:0] s_spo,
  input  logic        s_ready,
  output logic        timeout_err,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Last WAIT count before the watchdog fires.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_q, grant_d;
  logic        we_q, we_d;
  logic [31:0] s_a_q, s_a_d;
  logic [31:0] s_d_q, s_d_d;
  logic        s_we_q, s_we_d;
  logic        s_rd_q, s_rd_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] m0_spo_q, m0_spo_d;
  logic [31:0] m1_spo_q, m1_spo_d;
  logic        m0_ready_q, m0_ready_d;
  logic        m1_ready_q, m1_ready_d;
  logic        timeout_err_q, timeout_err_d;

  logic req0, req1, gnt, sel_we, sel_rd;

  assign req0 = m0_we | m0_rd;
  assign req1 = m1_we | m1_rd;

  // On a tie the requester that did not win last time is chosen.
  assign gnt    = (req0 && req1) ? ~last_grant_q : req1;
  assign sel_we = gnt ? m1_we : m0_we;
  assign sel_rd = (gnt ? m1_rd : m0_rd) & ~sel_we;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    we_d          = we_q;
    s_a_d         = s_a_q;
    s_d_d         = s_d_q;
    s_we_d        = 1'b0;
    s_rd_d        = 1'b0;
    cnt_d         = cnt_q;
    m0_spo_d      = m0_spo_q;
    m1_spo_d      = m1_spo_q;
    m0_ready_d    = 1'b0;
    m1_ready_d    = 1'b0;
    timeout_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          grant_d = gnt;
          we_d    = sel_we;
          s_a_d   = gnt ? m1_a : m0_a;
          s_d_d   = gnt ? m1_d : m0_d;
          // Strobes are registered here so they are high exactly in ISSUE.
          s_we_d  = sel_we;
          s_rd_d  = sel_rd;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        cnt_d   = 16'd0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (s_ready) begin
          // Writes leave the requester's read-data register untouched.
          if (!we_q) begin
            if (grant_q) m1_spo_d = s_spo;
            else         m0_spo_d = s_spo;
          end
          m0_ready_d = ~grant_q;
          m1_ready_d = grant_q;
          state_d    = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          if (grant_q) m1_spo_d = ERR_DATA;
          else         m0_spo_d = ERR_DATA;
          m0_ready_d    = ~grant_q;
          m1_ready_d    = grant_q;
          timeout_err_d = 1'b1;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_RESP: begin
        // m*_ready / timeout_err are already high this cycle (registered).
        last_grant_d = grant_q;
        state_d      = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= 1'b1;
      grant_q       <= 1'b0;
      we_q          <= 1'b0;
      s_a_q         <= 32'd0;
      s_d_q         <= 32'd0;
      s_we_q        <= 1'b0;
      s_rd_q        <= 1'b0;
      cnt_q         <= 16'd0;
      m0_spo_q      <= 32'd0;
      m1_spo_q      <= 32'd0;
      m0_ready_q    <= 1'b0;
      m1_ready_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      we_q          <= we_d;
      s_a_q         <= s_a_d;
      s_d_q         <= s_d_d;
      s_we_q        <= s_we_d;
      s_rd_q        <= s_rd_d;
      cnt_q         <= cnt_d;
      m0_spo_q      <= m0_spo_d;
      m1_spo_q      <= m1_spo_d;
      m0_ready_q    <= m0_ready_d;
      m1_ready_q    <= m1_ready_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign m0_spo      = m0_spo_q;
  assign m1_spo      = m1_spo_q;
  assign m0_ready    = m0_ready_q;
  assign m1_ready    = m1_ready_q;
  assign s_a         = s_a_q;
  assign s_d         = s_d_q;
  assign s_we        = s_we_q;
  assign s_rd        = s_rd_q;
  assign timeout_err = timeout_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Testbench for rr_bus_arbiter: directed steps followed by random
// transactions, checked against a transaction-level model of the arbiter
// (grant choice, latency, returned data) kept in this file.
module tb_rr_bus_arbiter;

  // TIMEOUT=6 lets a 5-cycle stall complete on the last legal WAIT cycle.
  localparam int unsigned TIMEOUT  = 6;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] m0_a, m0_d, m1_a, m1_d, s_spo;
  logic        m0_we, m0_rd, m1_we, m1_rd, s_ready;
  logic [31:0] m0_spo, m1_spo, s_a, s_d;
  logic        m0_ready, m1_ready, s_we, s_rd, timeout_err;
  logic [1:0]  dbg_state;

  rr_bus_arbiter #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
    .clk(clk), .rst(rst),
    .m0_a(m0_a), .m0_d(m0_d), .m0_we(m0_we), .m0_rd(m0_rd),
    .m0_spo(m0_spo), .m0_ready(m0_ready),
    .m1_a(m1_a), .m1_d(m1_d), .m1_we(m1_we), .m1_rd(m1_rd),
    .m1_spo(m1_spo), .m1_ready(m1_ready),
    .s_a(s_a), .s_d(s_d), .s_we(s_we), .s_rd(s_rd),
    .s_spo(s_spo), .s_ready(s_ready),
    .timeout_err(timeout_err), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [33:0] exp_q[$];        // {timed_out, grantee, grantee read data}
  logic [31:0] exp_spo[2];      // model of each requester's read-data register
  int          m_last;          // model: last granted requester

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_m0_spo"}, m0_spo, 0);
    check({tag, "_m1_spo"}, m1_spo, 0);
    check({tag, "_m0_ready"}, m0_ready, 0);
    check({tag, "_m1_ready"}, m1_ready, 0);
    check({tag, "_s_a"}, s_a, 0);
    check({tag, "_s_d"}, s_d, 0);
    check({tag, "_s_we"}, s_we, 0);
    check({tag, "_s_rd"}, s_rd, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  task automatic clear_requests();
    m0_we = 1'b0; m0_rd = 1'b0; m1_we = 1'b0; m1_rd = 1'b0;
  endtask

  task automatic model_reset();
    m_last = 1;
    exp_spo[0] = 32'd0;
    exp_spo[1] = 32'd0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_requests();
    m0_a = 0; m0_d = 0; m1_a = 0; m1_d = 0;
    s_ready = 1'b0; s_spo = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- driver: one complete transaction ----------------
  // stall = number of WAIT cycles with s_ready low before it rises;
  // stall >= TIMEOUT means the slave never answers.
  // early: s_ready high during ISSUE (must be ignored).
  // drop:  requests removed in the first WAIT cycle.
  task automatic run_txn(input logic w0, input logic r0, input logic w1, input logic r1,
                         input logic [31:0] a0, input logic [31:0] d0,
                         input logic [31:0] a1, input logic [31:0] d1,
                         input int stall, input logic early, input logic drop,
                         input logic [31:0] spo_val);
    int          win, lat;
    logic        win_b, ewe, erd, eto, q0, q1;
    logic [31:0] ea, ed;
    logic [33:0] exp;
    q0 = w0 | r0;
    q1 = w1 | r1;
    if (q0 && q1) win = 1 - m_last;
    else          win = q1 ? 1 : 0;
    win_b = (win == 1);
    ewe   = win_b ? w1 : w0;
    erd   = (win_b ? r1 : r0) & ~ewe;
    ea    = win_b ? a1 : a0;
    ed    = win_b ? d1 : d0;
    eto   = (stall >= int'(TIMEOUT));
    lat   = eto ? int'(TIMEOUT) + 2 : stall + 3;
    if (eto)       exp_spo[win] = ERR_DATA;
    else if (!ewe) exp_spo[win] = spo_val;
    exp_q.push_back({eto, win_b, exp_spo[win]});

    @(negedge clk);
    m0_we = w0; m0_rd = r0; m0_a = a0; m0_d = d0;
    m1_we = w1; m1_rd = r1; m1_a = a1; m1_d = d1;
    s_ready = 1'b0;
    s_spo   = $urandom;
    for (int c = 1; c <= lat + 1; c++) begin
      @(posedge clk);
      #1;
      check("m0_ready_timing", m0_ready, (c == lat) && !win_b);
      check("m1_ready_timing", m1_ready, (c == lat) && win_b);
      if (c == 1) begin
        check("issue_s_we", s_we, ewe);
        check("issue_s_rd", s_rd, erd);
        check("issue_s_a", s_a, ea);
        check("issue_s_d", s_d, ed);
        s_ready = early;
        s_spo   = $urandom;
      end else if (c < lat) begin
        check("wait_strobes", {s_we, s_rd}, 0);
        check("wait_s_a", s_a, ea);
        check("wait_s_d", s_d, ed);
        check("wait_timeout_err", timeout_err, 0);
        if (drop && c == 2) clear_requests();
        s_ready = ((c - 2) == stall);
        s_spo   = s_ready ? spo_val : $urandom;
      end else if (c == lat) begin
        exp = exp_q.pop_front();
        check("resp_scoreboard", {timeout_err, m1_ready, (win_b ? m1_spo : m0_spo)}, exp);
        check("resp_other_spo", win_b ? m0_spo : m1_spo, exp_spo[1 - win]);
        check("resp_strobes", {s_we, s_rd}, 0);
        clear_requests();
        s_ready = 1'($urandom_range(0, 1));
        s_spo   = $urandom;
      end else begin
        check("idle_timeout_err", timeout_err, 0);
        s_ready = 1'b0;
      end
    end
    m_last = win;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        w0, r0, w1, r1;
    int          mask;
    logic [31:0] ra0, ra1, rd0, rd1, rs;

    do_reset();
    #1;
    check_outputs_zero("reset");

    // Single read from requester 0, slave answers immediately.
    run_txn(0, 1, 0, 0, 32'h0000_1000, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h1234_5678);

    // Tie after reset-style last_grant: grant order alternates 0,1,0,1.
    do_reset();
    for (int i = 0; i < 4; i++)
      run_txn(1, 0, 0, 1, 32'hA000_0000 + i, 32'hD000_0000 + i,
              32'hB000_0000 + i, 32'hE000_0000 + i, 0, 0, 0, 32'h5500_0000 + i);

    // Slow slave: 5 stalled WAIT cycles (last legal one completes).
    run_txn(0, 0, 0, 1, 32'h0, 32'h0, 32'h0000_2222, 32'h0, 5, 0, 0, 32'hCAFE_0001);

    // Slave stuck: watchdog returns ERR_DATA.
    run_txn(0, 1, 0, 0, 32'h0000_3333, 32'h0, 32'h0, 32'h0, 1000, 0, 0, 32'h0);

    // Requester drops mid-WAIT and s_ready during ISSUE must be ignored.
    run_txn(0, 0, 0, 1, 32'h0, 32'h0, 32'h0000_4444, 32'h0, 2, 1, 1, 32'h0BAD_F00D);

    // Write completes without touching read data; write timeout loads ERR_DATA.
    run_txn(1, 1, 0, 0, 32'h0000_5555, 32'h1111_2222, 32'h0, 32'h0, 1, 0, 0, 32'h7777_7777);
    run_txn(0, 0, 1, 0, 32'h0, 32'h0, 32'h0000_6666, 32'h3333_4444, 1000, 0, 0, 32'h0);

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      mask = $urandom_range(1, 3);
      w0 = 1'($urandom_range(0, 1)); r0 = w0 ? 1'($urandom_range(0, 1)) : 1'b1;
      w1 = 1'($urandom_range(0, 1)); r1 = w1 ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mask[0] == 1'b0) begin w0 = 1'b0; r0 = 1'b0; end
      if (mask[1] == 1'b0) begin w1 = 1'b0; r1 = 1'b0; end
      ra0 = $urandom; ra1 = $urandom; rd0 = $urandom; rd1 = $urandom; rs = $urandom;
      run_txn(w0, r0, w1, r1, ra0, rd0, ra1, rd1,
              $urandom_range(0, TIMEOUT + 1), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), rs);
    end

    // Make requester 0 the last grantee, then reset in the middle of WAIT.
    run_txn(0, 1, 0, 0, 32'h0000_7000, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0000_00AA);
    @(negedge clk);
    m1_rd = 1'b1; m1_a = 32'h0000_8000; s_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_wait_s_a", s_a, 32'h0000_8000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_requests();
    check_outputs_zero("mid_reset");
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("post_reset_no_ready", {m0_ready, m1_ready}, 0);
    end
    // Next tie must go to requester 0 again.
    run_txn(0, 1, 0, 1, 32'h0000_9000, 32'h0, 32'h0000_9100, 32'h0, 0, 0, 0, 32'h0000_0F0F);
    run_txn(0, 1, 0, 1, 32'h0000_9000, 32'h0, 32'h0000_9100, 32'h0, 0, 0, 0, 32'h0000_F0F0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
